// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// legality checks and store lane/data formatting.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    Idle,
    Settle,
    Wait,
    Commit,
    Resp,
    Err
  } state_e;

  // Halves need an even address and words a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3[1:0])
      2'b01:   return addr[0];
      2'b10:   return addr != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic       write,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr);
    logic bad_f3;
    if (write) bad_f3 = funct3[2] || (funct3[1:0] == 2'b11);
    else       bad_f3 = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
    return bad_f3 || is_misaligned(funct3, addr);
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << addr;
      2'b01:   return 4'b0011 << {addr[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a cache word and sign- or zero-extends it
// according to the load funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    value = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    value = {{16{half_lane[15]}}, half_lane};
      F3_BU:   value = {24'h0, byte_lane};
      F3_HU:   value = {16'h0, half_lane};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Bridges the core's load/store stage to the unified cache port: aligns accesses,
// formats store lanes, extends load data, and counts hits and misses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int CounterBitWidth = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [2:0]                 req_funct3,
  input  logic [31:0]                req_address,
  input  logic [31:0]                req_wdata,
  output logic                       resp_valid,
  output logic [31:0]                resp_rdata,
  output logic                       resp_error,
  output logic                       cache_enable,
  output logic [31:0]                cache_address,
  output logic [3:0]                 cache_write_enable,
  output logic [31:0]                cache_data_in,
  input  logic [31:0]                cache_data_out,
  input  logic                       cache_busy,
  output logic [CounterBitWidth-1:0] hit_count,
  output logic [CounterBitWidth-1:0] miss_count
);

  state_e      state, next_state;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        missed_q;
  logic [31:0] load_value;
  logic [31:0] line_address;

  assign line_address = {addr_q[31:2], 2'b00};

  load_extend u_load_extend (
    .word   (cache_data_out),
    .addr   (addr_q[1:0]),
    .funct3 (funct3_q),
    .value  (load_value)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= Idle;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      Idle:    if (req_valid)
                 next_state = is_illegal(req_write, req_funct3, req_address[1:0]) ? Err : Settle;
      Settle:  next_state = Wait;
      Wait:    if (!cache_busy) next_state = write_q ? Commit : Resp;
      Commit:  next_state = Resp;
      Resp:    next_state = Idle;
      Err:     next_state = Idle;
      default: next_state = Idle;
    endcase
  end

  // Request fields are captured once at acceptance; the core may change them afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      missed_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == Idle && req_valid) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_address;
        wdata_q  <= req_wdata;
        missed_q <= 1'b0;
      end
      if (state == Wait) begin
        if (cache_busy)    missed_q <= 1'b1;
        else if (!write_q) rdata_q  <= load_value;
      end
      if (state == Resp) begin
        if (missed_q) miss_count <= miss_count + 1'b1;
        else          hit_count  <= hit_count + 1'b1;
      end
    end
  end

  // Outputs are forced to reset values while rst is high so an abandoned store
  // can never reach Commit's write enables in the reset cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    req_ready          = 1'b0;
    resp_valid         = 1'b0;
    resp_error         = 1'b0;
    resp_rdata         = 32'h0;
    cache_enable       = 1'b0;
    cache_address      = 32'h0;
    cache_write_enable = 4'b0000;
    cache_data_in      = 32'h0;
    if (rst) begin
      req_ready = 1'b1;
    end else begin
      case (state)
        Idle: req_ready = 1'b1;
        Settle, Wait: begin
          cache_enable  = 1'b1;
          cache_address = line_address;
        end
        Commit: begin
          cache_enable       = 1'b1;
          cache_address      = line_address;
          cache_write_enable = store_mask(funct3_q, addr_q[1:0]);
          cache_data_in      = store_data(funct3_q, wdata_q);
        end
        Resp: begin
          resp_valid    = 1'b1;
          resp_rdata    = write_q ? 32'h0 : rdata_q;
          cache_address = line_address;
        end
        Err: begin
          resp_valid = 1'b1;
          resp_error = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a behavioural cache array, a response
// scoreboard with latency tracking, and immediate-assertion checks.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        cache_enable;
  logic [31:0] cache_address;
  logic [3:0]  cache_write_enable;
  logic [31:0] cache_data_in;
  logic [31:0] cache_data_out;
  logic        cache_busy;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  load_store_unit #(.CounterBitWidth(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_funct3         (req_funct3),
    .req_address        (req_address),
    .req_wdata          (req_wdata),
    .resp_valid         (resp_valid),
    .resp_rdata         (resp_rdata),
    .resp_error         (resp_error),
    .cache_enable       (cache_enable),
    .cache_address      (cache_address),
    .cache_write_enable (cache_write_enable),
    .cache_data_in      (cache_data_in),
    .cache_data_out     (cache_data_out),
    .cache_busy         (cache_busy),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_cyc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          we_cycles = 0;
  int          en_cycles = 0;
  logic [3:0]  last_we = 4'b0000;
  logic [31:0] last_din = 32'h0;
  logic [31:0] mem [0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Cache model: combinational read, byte-lane write on the clock edge.
  assign cache_data_out = mem[cache_address[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]    <= 32'hDEAD_BEEF;
      mem[8]    <= 32'h5555_6666;
      mem[12]   <= 32'h0BAD_0BAD;
      mem[8'h40] <= 32'h8001_7FFE;
    end else if (cache_enable) begin
      for (int i = 0; i < 4; i++)
        if (cache_write_enable[i]) mem[cache_address[9:2]][8*i +: 8] <= cache_data_in[8*i +: 8];
    end
  end

  // Response monitor and write-lane recorder.
  always @(negedge clk) begin
    if (cache_write_enable != 4'b0000) begin
      we_cycles <= we_cycles + 1;
      last_we   <= cache_write_enable;
      last_din  <= cache_data_in;
    end
    if (cache_enable) en_cycles <= en_cycles + 1;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_rdata"}, resp_rdata, mon_e.rdata);
        chk({mon_e.tag, "_error"}, {31'h0, resp_error}, {31'h0, mon_e.err});
        chk({mon_e.tag, "_latency"}, cyc - mon_e.acc_cyc, mon_e.lat);
      end
    end
  end

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk({tag, "_ready_timeout"}, {31'h0, req_ready}, 32'h1);
    req_valid   = 1'b1;
    req_write   = w;
    req_funct3  = f3;
    req_address = a;
    req_wdata   = wd;
    sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat, acc_cyc: cyc, tag: tag});
    @(posedge clk);
    @(negedge clk);
    req_valid   = 1'b0;
    req_address = 32'hFFFF_FFFF;
    req_funct3  = 3'b111;
    req_wdata   = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("resp_timeout", sb.size(), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int we0;
  int en0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_address = 32'h0; req_wdata = 32'h0; cache_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_cache_enable", {31'h0, cache_enable}, 32'h0);
    chk("rst_cache_address", cache_address, 32'h0);
    chk("rst_cache_we", {28'h0, cache_write_enable}, 32'h0);
    chk("rst_cache_din", cache_data_in, 32'h0);
    chk("rst_hit_count", hit_count, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);

    // Word load hit.
    do_req(1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, "lw_hit");
    wait_done();
    chk("lw_hit_count", hit_count, 32'd1);

    // Byte store into lane 3, then unsigned and signed byte reloads.
    we0 = we_cycles;
    do_req(1'b1, F3_B, 32'h13, 32'h0000_00A5, 32'h0, 1'b0, 4, "sb");
    wait_done();
    chk("sb_we", {28'h0, last_we}, 32'h8);
    chk("sb_din", last_din, 32'hA5A5_A5A5);
    chk("sb_we_cycles", we_cycles - we0, 32'd1);
    do_req(1'b0, F3_BU, 32'h13, 32'h0, 32'h0000_00A5, 1'b0, 3, "lbu");
    do_req(1'b0, F3_B, 32'h13, 32'h0, 32'hFFFF_FFA5, 1'b0, 3, "lb");
    wait_done();
    chk("after_lb_hit_count", hit_count, 32'd4);

    // Signed half load that misses: busy for most of Wait.
    do_req(1'b0, F3_H, 32'h102, 32'h0, 32'hFFFF_8001, 1'b0, 22, "lh_miss");
    cache_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("miss_enable", {31'h0, cache_enable}, 32'h1);
      chk("miss_address", cache_address, 32'h100);
      chk("miss_we", {28'h0, cache_write_enable}, 32'h0);
    end
    cache_busy = 1'b0;
    wait_done();
    chk("miss_count", miss_count, 32'd1);
    chk("miss_hit_count", hit_count, 32'd4);

    // Misaligned and illegal-funct3 requests.
    en0 = en_cycles;
    do_req(1'b1, F3_W, 32'h6, 32'h1111_2222, 32'h0, 1'b1, 1, "sw_misaligned");
    do_req(1'b0, F3_HU, 32'h1, 32'h0, 32'h0, 1'b1, 1, "lhu_misaligned");
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, "ld_illegal_f3");
    do_req(1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 1, "st_illegal_f3");
    wait_done();
    chk("err_no_enable", en_cycles - en0, 32'd0);
    chk("err_hit_count", hit_count, 32'd4);
    chk("err_miss_count", miss_count, 32'd1);

    // Reset while a store waits on the cache.
    we0 = we_cycles;
    do_req(1'b1, F3_W, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, 4, "sw_reset");
    cache_busy = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rstmid_we", {28'h0, cache_write_enable}, 32'h0);
    chk("rstmid_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rstmid_enable", {31'h0, cache_enable}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cache_busy = 1'b0;
    #1;
    chk("rstpost_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rstpost_enable", {31'h0, cache_enable}, 32'h0);
    chk("rstpost_address", cache_address, 32'h0);
    chk("rstpost_hit_count", hit_count, 32'h0);
    chk("rstpost_miss_count", miss_count, 32'h0);
    repeat (4) @(negedge clk);
    chk("rstpost_no_write", we_cycles - we0, 32'd0);
    chk("rstpost_mem", mem[12], 32'h0BAD_0BAD);

    // Back-to-back half store then word load of the same line.
    do_req(1'b1, F3_H, 32'h22, 32'h0000_1234, 32'h0, 1'b0, 4, "sh");
    do_req(1'b0, F3_W, 32'h20, 32'h0, 32'h1234_6666, 1'b0, 3, "lw_after_sh");
    wait_done();
    chk("sh_we", {28'h0, last_we}, 32'hC);
    chk("sh_din", last_din, 32'h1234_1234);
    chk("b2b_hit_count", hit_count, 32'd2);
    chk("b2b_miss_count", miss_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the SDRAM-backed unified cache, between the RISC-V core's load/store stage and the cache port.
- Converts core requests (funct3, byte address, store data) into word-aligned cache accesses: byte-lane masks, store data replication, load byte extraction and sign/zero extension.
- Holds address and write_enable stable across cache busy, plus the cache's one-cycle tag-settle rule.
- Reports misalignment and keeps hit/miss counters.

Parameters:
- CounterBitWidth, 32, width of hit_count and miss_count; both counters wrap.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- req_valid  input  1  core presents a request
- req_ready  output  1  request accepted on clock edge when req_valid && req_ready
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_address  input  32  byte address
- req_wdata  input  32  store data, low-aligned
- resp_valid  output  1  one-cycle completion pulse, no backpressure
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  misaligned access or illegal funct3, valid with resp_valid
- cache_enable  output  1  to cache enable
- cache_address  output  32  to cache address; bits [1:0] always 0
- cache_write_enable  output  4  to cache byte write enables
- cache_data_in  output  32  to cache data_in
- cache_data_out  input  32  from cache
- cache_busy  input  1  from cache; miss refill/evict in progress
- hit_count  output  CounterBitWidth  completed accesses that found the line resident
- miss_count  output  CounterBitWidth  completed accesses that saw cache_busy in Wait

Behaviour:
- Reset values:
  - State Idle, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0.
  - cache_enable=0, cache_write_enable=0, cache_address=0, cache_data_in=0.
  - Both counters 0.
  - Reset mid-access abandons the access immediately. cache_write_enable is 0 in the reset cycle. No resp_valid is issued.
- Requests are latched at acceptance and never sampled again.
- Legality:
  - Loads: funct3 011/110/111 are illegal. LH/LHU need addr[0]=0; LW needs addr[1:0]=0.
  - Stores: funct3[2]=1 or 011 is illegal. SH needs addr[0]=0; SW needs addr[1:0]=0.
- Store lanes:
  - SB: mask=4'b0001<<addr[1:0], data={4{wdata[7:0]}}.
  - SH: mask=4'b0011<<{addr[1],1'b0}, data={2{wdata[15:0]}}.
  - SW: mask=4'b1111, data=wdata.
- Load extraction:
  - Byte or half is selected by addr[1:0] from cache_data_out.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- FSM:
  - Idle: req_ready=1. On accept, an illegal request goes to Err. Otherwise drive cache_enable=1, cache_address={addr[31:2],2'b00}, cache_write_enable=0, and go to Settle.
  - Settle: 1 cycle; the cache's tag BRAM output is stale, so cache_busy is ignored. Go to Wait.
  - Wait: hold all cache outputs.
    - If cache_busy: set a sticky missed flag and stay.
    - Else, for a load: register the extracted data and go to Resp.
    - Else, for a store: go to Commit.
  - Commit (store only): cache_write_enable=mask, cache_data_in=replicated data for exactly one cycle. Go to Resp.
  - Resp: resp_valid=1. cache_write_enable=0 and cache_enable=0, but cache_address is held (the cache's hold-plus-one rule). Increment miss_count if missed, else hit_count. Go to Idle.
  - Err: resp_valid=1, resp_error=1, no cache activity, no counter change. Go to Idle.
- Latency from accept edge to resp_valid:
  - Load hit: 3 cycles.
  - Store hit: 4 cycles.
  - Miss: 3 or 4 cycles plus the busy duration.
  - Error: 1 cycle.
- Throughput: req_ready is high only in Idle. The next request can be accepted in the cycle after Resp or Err.
- cache_write_enable is nonzero only in Commit. Writes are never exposed while the tag output is unsettled.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state_e enum {Idle, Settle, Wait, Commit, Resp, Err}.
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module load_extend (combinational): inputs word, addr[1:0], funct3; output 32-bit extended value. Stores reuse the package function for lane masks.

Test Plan:
- LW 0x0000_0010, line resident holding 0xDEAD_BEEF -> resp_valid 3 cycles after accept, rdata=0xDEAD_BEEF, error=0, hit_count=1.
- SB 0x0000_0013, wdata=0x0000_00A5 -> in Commit, cache_write_enable=4'b1000 and data_in=0xA5A5_A5A5. A following LBU 0x13 returns 0x0000_00A5; LB returns 0xFFFF_FFA5.
- LH 0x0000_0102, cache_busy held 20 cycles after Settle -> address/enable stable throughout, write_enable 0, resp_valid once, miss_count=1.
- SW 0x0000_0006 and LHU 0x0000_0001 -> resp_valid+resp_error next cycle, cache_enable never asserted, counters unchanged.
- rst pulsed during Wait of a store -> no Commit, cache_write_enable stays 0, outputs at reset values, req_ready=1 next cycle.
- Back-to-back SH 0x0000_0022 (wdata 0x1234) then LW 0x0000_0020 -> cache_write_enable=4'b1100, data_in=0x1234_1234. The load returns the upper half 0x1234 with the lower half unchanged.
